// File: rtl/nand2_resp_checker.sv
// Response checker for a 2-input NAND under test: scores (a,b,o) samples against ~(a&b).
// Optional idle timeout is compiled in with `define NAND2_CHK_TIMEOUT_EN.
module nand2_resp_checker #(
  parameter int CNT_W   = 8,
  parameter int EXP_N   = 4,
  parameter int TMO_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_o,
  output logic             smp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [2:0]       first_err_vec
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic             r_ready, r_busy, r_done, r_pass, r_timeout;
  logic [CNT_W-1:0] r_cnt, r_err, r_first_idx;
  logic [3:0]       r_cov;
  logic [2:0]       r_first_vec;

  logic             w_accept, w_mis, w_last, w_tmo;
  logic [CNT_W-1:0] w_cnt_nxt, w_err_nxt;
  logic [3:0]       w_cov_nxt;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_accept  = smp_valid & r_ready;
    w_mis     = w_accept & (smp_o != ~(smp_a & smp_b));
    w_cov_nxt = r_cov;
    if (w_accept) w_cov_nxt[{smp_a, smp_b}] = 1'b1;
    w_err_nxt = r_err;
    if (w_mis && (r_err != {CNT_W{1'b1}})) w_err_nxt = r_err + 1'b1;
    w_cnt_nxt = r_cnt + CNT_W'(w_accept);
    w_last    = w_accept && (w_cnt_nxt == CNT_W'(EXP_N));
  end

`ifdef NAND2_CHK_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TMO_CYC + 1);
  logic [IDLE_W-1:0] r_idle;

  // Fires on the TMO_CYC-th consecutive RUN cycle without an accept.
  assign w_tmo = (r_state == S_RUN) && !w_accept && (r_idle == IDLE_W'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_RUN) || w_accept) r_idle <= '0;
    else if (!w_tmo)                           r_idle <= r_idle + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  // NOTE: state and counters use non-blocking assignments so every update
  // sees the pre-edge values, matching the register semantics of the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
      r_err       <= '0;
      r_cov       <= '0;
      r_first_idx <= '0;
      r_first_vec <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
            r_err       <= '0;
            r_cov       <= '0;
            r_first_idx <= '0;
            r_first_vec <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
            r_cov <= w_cov_nxt;
            if (w_mis && (r_err == '0)) begin
              r_first_idx <= r_cnt;
              r_first_vec <= {smp_a, smp_b, smp_o};
            end
          end
          // The verdict uses the post-update values of the final accept.
          if (w_last || w_tmo) begin
            r_state   <= S_DONE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= w_tmo;
            r_pass    <= w_last && (w_err_nxt == '0) && (w_cov_nxt == 4'hF);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign smp_ready     = r_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign smp_cnt       = r_cnt;
  assign err_cnt       = r_err;
  assign cov           = r_cov;
  assign first_err_idx = r_first_idx;
  assign first_err_vec = r_first_vec;

endmodule

// File: tb/tb_nand2_resp_checker.sv
// Directed self-checking bench for nand2_resp_checker (main instance EXP_N=4, second EXP_N=2).
module tb_nand2_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, smp_valid, smp_a, smp_b, smp_o;
  logic       smp_ready, busy, done, pass, timeout;
  logic [7:0] smp_cnt, err_cnt, first_err_idx;
  logic [3:0] cov;
  logic [2:0] first_err_vec;

  logic       ready2, busy2, done2, pass2, timeout2;
  logic [7:0] cnt2, err2, fidx2;
  logic [3:0] cov2;
  logic [2:0] fvec2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  nand2_resp_checker #(.CNT_W(8), .EXP_N(4), .TMO_CYC(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .smp_a(smp_a), .smp_b(smp_b), .smp_o(smp_o),
    .smp_ready(smp_ready), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .smp_cnt(smp_cnt), .err_cnt(err_cnt), .cov(cov),
    .first_err_idx(first_err_idx), .first_err_vec(first_err_vec)
  );

  nand2_resp_checker #(.CNT_W(8), .EXP_N(2), .TMO_CYC(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .smp_a(smp_a), .smp_b(smp_b), .smp_o(smp_o),
    .smp_ready(ready2), .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2),
    .smp_cnt(cnt2), .err_cnt(err2), .cov(cov2),
    .first_err_idx(fidx2), .first_err_vec(fvec2)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; smp_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic a, input logic b, input logic o);
    smp_valid = 1'b1; smp_a = a; smp_b = b; smp_o = o;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic test_reset();
    smp_a = 1'b0; smp_b = 1'b0; smp_o = 1'b0;
    do_reset();
    n_total++;
    if ({smp_ready, busy, done, pass, timeout, smp_cnt, err_cnt, cov, first_err_idx, first_err_vec} !== '0)
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b pass=%b tmo=%b cnt=%0d err=%0d cov=%b, want all 0",
               smp_ready, busy, done, pass, timeout, smp_cnt, err_cnt, cov);
    else n_pass++;
    // Valid without start must not be accepted.
    smp_valid = 1'b1; smp_a = 1'b1; smp_b = 1'b1; smp_o = 1'b1;
    repeat (3) tick();
    smp_valid = 1'b0;
    n_total++;
    if ({smp_ready, busy, smp_cnt, err_cnt} !== '0)
      $display("FAIL idle_ignore: got rdy=%b busy=%b cnt=%0d err=%0d, want 0", smp_ready, busy, smp_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_good();
    pulse_start();
    n_total++;
    if ({busy, done, smp_ready, smp_cnt} !== {3'b101, 8'd0})
      $display("FAIL run_entry: got busy=%b done=%b rdy=%b cnt=%0d, want 1 0 1 0", busy, done, smp_ready, smp_cnt);
    else n_pass++;
    send(0, 0, 1); smp_valid = 1'b1;
    send(0, 1, 1); smp_valid = 1'b1;
    send(1, 0, 1);
    n_total++;
    if ({done, smp_cnt} !== {1'b0, 8'd3})
      $display("FAIL good_mid: got done=%b cnt=%0d, want 0 3", done, smp_cnt);
    else n_pass++;
    send(1, 1, 0);
    n_total++;
    if ({busy, done, smp_ready, pass, err_cnt, cov, smp_cnt} !== {4'b0101, 8'd0, 4'hF, 8'd4})
      $display("FAIL good_verdict: got busy=%b done=%b rdy=%b pass=%b err=%0d cov=%b cnt=%0d, want 0 1 0 1 0 1111 4",
               busy, done, smp_ready, pass, err_cnt, cov, smp_cnt);
    else n_pass++;
    // Valid (with a bad sample) while DONE must be ignored.
    smp_valid = 1'b1; smp_a = 1'b0; smp_b = 1'b0; smp_o = 1'b0;
    repeat (2) tick();
    smp_valid = 1'b0;
    n_total++;
    if ({done, pass, smp_cnt, err_cnt} !== {2'b11, 8'd4, 8'd0})
      $display("FAIL done_ignore: got done=%b pass=%b cnt=%0d err=%0d, want 1 1 4 0", done, pass, smp_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_fault();
    pulse_start();  // restart from DONE
    n_total++;
    if ({busy, done, pass, smp_cnt, err_cnt, cov} !== {3'b100, 8'd0, 8'd0, 4'h0})
      $display("FAIL restart_clear: got busy=%b done=%b pass=%b cnt=%0d err=%0d cov=%b, want 1 0 0 0 0 0000",
               busy, done, pass, smp_cnt, err_cnt, cov);
    else n_pass++;
    send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 1);
    n_total++;
    if ({done, pass, err_cnt, first_err_idx, first_err_vec, cov} !== {2'b10, 8'd1, 8'd3, 3'b111, 4'hF})
      $display("FAIL single_fault: got done=%b pass=%b err=%0d fidx=%0d fvec=%b cov=%b, want 1 0 1 3 111 1111",
               done, pass, err_cnt, first_err_idx, first_err_vec, cov);
    else n_pass++;
  endtask

  task automatic test_multi_err();
    pulse_start();
    send(0, 0, 0); send(0, 1, 1); send(1, 0, 0); send(1, 1, 0);
    n_total++;
    if ({done, pass, err_cnt, first_err_idx, first_err_vec, smp_cnt} !== {2'b10, 8'd2, 8'd0, 3'b000, 8'd4})
      $display("FAIL multi_err: got done=%b pass=%b err=%0d fidx=%0d fvec=%b cnt=%0d, want 1 0 2 0 000 4",
               done, pass, err_cnt, first_err_idx, first_err_vec, smp_cnt);
    else n_pass++;
  endtask

  task automatic test_cov_missing();
    pulse_start();
    send(0, 0, 1); send(0, 0, 1); send(0, 1, 1); send(1, 0, 1);
    n_total++;
    if ({done, pass, err_cnt, cov, smp_cnt} !== {2'b10, 8'd0, 4'b0111, 8'd4})
      $display("FAIL cov_missing: got done=%b pass=%b err=%0d cov=%b cnt=%0d, want 1 0 0 0111 4",
               done, pass, err_cnt, cov, smp_cnt);
    else n_pass++;
  endtask

  task automatic test_gaps();
    pulse_start();
    // Invalid cycles carry a bad sample that must not be scored.
    send(0, 0, 1);
    smp_a = 1'b1; smp_b = 1'b1; smp_o = 1'b1;
    repeat (2) tick();
    send(0, 1, 1);
    n_total++;
    if ({smp_cnt, err_cnt, cov} !== {8'd2, 8'd0, 4'b0011})
      $display("FAIL gaps_count: got cnt=%0d err=%0d cov=%b, want 2 0 0011", smp_cnt, err_cnt, cov);
    else n_pass++;
    tick();
    send(1, 0, 1);
    start = 1'b1;  // coincides with the final accept and must be ignored
    send(1, 1, 0);
    start = 1'b0;
    n_total++;
    if ({busy, done, pass, smp_cnt} !== {3'b011, 8'd4})
      $display("FAIL start_on_last: got busy=%b done=%b pass=%b cnt=%0d, want 0 1 1 4", busy, done, pass, smp_cnt);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, done, smp_ready} !== 3'b010)
      $display("FAIL done_hold: got busy=%b done=%b rdy=%b, want 0 1 0", busy, done, smp_ready);
    else n_pass++;
  endtask

  task automatic test_small_run();
    do_reset();
    pulse_start();
    send(0, 0, 1); send(1, 1, 0);
    n_total++;
    if ({busy2, done2, ready2, pass2, err2, cov2, cnt2} !== {4'b0100, 8'd0, 4'b1001, 8'd2})
      $display("FAIL short_run: got busy=%b done=%b rdy=%b pass=%b err=%0d cov=%b cnt=%0d, want 0 1 0 0 0 1001 2",
               busy2, done2, ready2, pass2, err2, cov2, cnt2);
    else n_pass++;
    n_total++;
    if ({busy, done, smp_cnt} !== {2'b10, 8'd2})
      $display("FAIL long_run_mid: got busy=%b done=%b cnt=%0d, want 1 0 2", busy, done, smp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Continues the run left by test_small_run (2 accepts taken).
    smp_valid = 1'b1; smp_a = 1'b1; smp_b = 1'b0; smp_o = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if ({smp_ready, busy, done, pass, timeout, smp_cnt, err_cnt, cov, first_err_idx, first_err_vec} !== '0)
      $display("FAIL reset_mid: got rdy=%b busy=%b done=%b cnt=%0d err=%0d cov=%b, want all 0",
               smp_ready, busy, done, smp_cnt, err_cnt, cov);
    else n_pass++;
    repeat (2) tick();
    smp_valid = 1'b0;
    n_total++;
    if ({smp_ready, busy, smp_cnt, err_cnt} !== '0)
      $display("FAIL reset_mid_idle: got rdy=%b busy=%b cnt=%0d err=%0d, want 0", smp_ready, busy, smp_cnt, err_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    pulse_start();
    send(0, 0, 1);
`ifdef NAND2_CHK_TIMEOUT_EN
    repeat (15) tick();
    n_total++;
    if ({busy, done} !== 2'b10)
      $display("FAIL tmo_early: got busy=%b done=%b, want 1 0", busy, done);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, done, timeout, pass, smp_cnt} !== {4'b0110, 8'd1})
      $display("FAIL tmo_fire: got busy=%b done=%b tmo=%b pass=%b cnt=%0d, want 0 1 1 0 1",
               busy, done, timeout, pass, smp_cnt);
    else n_pass++;
`else
    repeat (20) tick();
    n_total++;
    if ({busy, done, timeout, smp_cnt} !== {3'b100, 8'd1})
      $display("FAIL no_tmo: got busy=%b done=%b tmo=%b cnt=%0d, want 1 0 0 1", busy, done, timeout, smp_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; smp_valid = 1'b0;
    smp_a = 1'b0; smp_b = 1'b0; smp_o = 1'b0;
    test_reset();
    test_good();
    test_fault();
    test_multi_err();
    test_cov_missing();
    test_gaps();
    test_small_run();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nand2_resp_checker.md
Name: nand2_resp_checker

Overview:
- Synthesizable response checker at the receiving end of the NAND2 stimulus/monitor path.
- Accepts sampled (a, b, o) vectors from a 2-input NAND under test via a valid/ready handshake.
- Compares each o against ~(a&b); counts samples and mismatches, tracks coverage of the 4 input combinations, captures the first failure.
- Reports a single pass/fail verdict per run; used on-chip and as the self-checking end of gate-level benches.

Parameters:
- CNT_W, 8, width of sample/error counters and first-error index.
- EXP_N, 4, samples per run; legal range 1..2^CNT_W-1.
- TMO_CYC, 16, idle-cycle limit for the optional timeout (used only with the feature compiled in).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run.
- smp_valid  input  1  sample present.
- smp_a  input  1  sampled input a.
- smp_b  input  1  sampled input b.
- smp_o  input  1  sampled gate output.
- smp_ready  output  1  checker accepts a sample this cycle.
- busy  output  1  run in progress.
- done  output  1  run complete; verdict valid.
- pass  output  1  verdict; valid only while done=1.
- timeout  output  1  run ended by idle timeout.
- smp_cnt  output  CNT_W  samples accepted this run.
- err_cnt  output  CNT_W  mismatches this run; saturates at all-ones.
- cov  output  4  bit {a,b} set once that combination has been seen.
- first_err_idx  output  CNT_W  smp_cnt value at the first mismatch.
- first_err_vec  output  3  {a,b,o} of the first mismatch.

Behaviour:
- Reset: synchronous, active-high, on clk rising edge.
  - FSM goes to IDLE.
  - All outputs go to 0: smp_ready, busy, done, pass, timeout, all counters, cov, first_err_*.
  - Reset has priority over every other input, including mid-run; a partial run is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - smp_ready=0; smp_valid is ignored.
  - start=1 -> RUN next cycle. On that edge clear smp_cnt, err_cnt, cov, first_err_*, timeout, pass.
- RUN:
  - busy=1, smp_ready=1.
  - start is ignored.
  - A sample is accepted on a cycle with smp_valid & smp_ready.
- On accept, all updates are registered with 1-cycle latency:
  - exp = ~(smp_a & smp_b); mismatch = (smp_o != exp).
  - cov[{smp_a,smp_b}] <= 1.
  - smp_cnt <= smp_cnt+1.
  - On mismatch: err_cnt increments, holding at 2^CNT_W-1.
  - On the first mismatch of the run only (err_cnt==0 before the update): first_err_idx <= smp_cnt (pre-increment), first_err_vec <= {a,b,o}.
- End of run:
  - The accept that brings smp_cnt to EXP_N moves the FSM to DONE on the same edge.
  - smp_ready drops the next cycle; further valids are not accepted.
- DONE:
  - done=1, busy=0, smp_ready=0.
  - pass = (err_cnt==0) && (cov==4'hF) && !timeout.
  - All results hold.
  - start=1 -> RUN with counters cleared, exactly as from IDLE. There is no return to IDLE except via rst.
- Boundaries:
  - EXP_N<4: cov can never reach 4'hF, so pass=0 by definition.
  - Repeated combinations count toward smp_cnt but do not change cov.
  - start coincident with the final accept: the accept is processed, the FSM enters DONE, and start is ignored.
  - Error saturation does not affect smp_cnt.

Optional Feature:
- Macro: NAND2_CHK_TIMEOUT_EN.
- Defined:
  - An idle counter increments on each RUN cycle without an accept and clears on accept and on entry to RUN.
  - When it reaches TMO_CYC, the FSM goes to DONE next edge with timeout=1; pass is then 0.
- Undefined:
  - No idle counter.
  - timeout is tied to 0.
  - RUN waits indefinitely for samples.

Test Plan:
- Exhaustive good DUT: rst, start, 4 samples {00,01,10,11} with o=1,1,1,0 and valid every cycle -> done=1 one cycle after the 4th accept, pass=1, err_cnt=0, cov=4'hF, smp_cnt=4.
- Single fault: same sequence with sample 3 (11) o=1 -> pass=0, err_cnt=1, first_err_idx=3, first_err_vec=3'b111.
- Missing coverage: EXP_N=4, samples 00,00,01,10 all correct -> cov=4'b0111 (bits 2:0 set, bit 3 clear), pass=0, err_cnt=0.
- Handshake gaps and restart:
  - smp_valid toggled 1,0,0,1,... -> only valid cycles counted.
  - Valid in IDLE/DONE -> ignored.
  - start in DONE -> counters cleared, new run behaves identically.
- Reset mid-run: rst asserted after 2 accepts -> next cycle all outputs 0, FSM IDLE; valid without start -> smp_ready=0, no counting.
- Timeout (NAND2_CHK_TIMEOUT_EN, TMO_CYC=16): start, 1 accept, then no valid for 16 cycles -> done=1, timeout=1, pass=0, smp_cnt=1. Without the macro -> busy stays 1, timeout=0.
